vertex_xform_seq: RTL and testbench

Sequences a batch of vertices from the vertex RAM through the shared combinational rotate/translate unit and streams the transformed vertices to the raster stage over a valid/ready handshake. Per job it latches the translation vector, presents one vertex per pass to the unit, and captures the unit's result. When the job completes it optionally advances the rotation angle for the next frame.

---
 rtl/vertex_xform_seq_if.sv | 23 ++
 rtl/vertex_xform_seq.sv | 135 +++++++++++++
 tb/tb_vertex_xform_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vertex_xform_seq_if.sv
// vertex_xform_seq_if: transformed-vertex stream from the sequencer to the raster stage.
interface vertex_xform_seq_if #(
    parameter int ADDR_W  = 8,
    parameter int COORD_W = 10
);
    logic               out_valid;
    logic               out_ready;
    logic [COORD_W-1:0] out_x;
    logic [COORD_W-1:0] out_y;
    logic [COORD_W-1:0] out_z;
    logic [ADDR_W-1:0]  out_idx;
    logic               out_last;

    modport master (
        output out_valid, out_x, out_y, out_z, out_idx, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_x, out_y, out_z, out_idx, out_last,
        output out_ready
    );
endinterface

// File: rtl/vertex_xform_seq.sv
// vertex_xform_seq: walks a vertex batch through the shared rotate/translate unit and streams the results.
module vertex_xform_seq #(
    parameter int ADDR_W  = 8,
    parameter int COORD_W = 10,
    parameter int ANG_W   = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W-1:0]    vcount,
    input  logic [COORD_W-1:0]   tx,
    input  logic [COORD_W-1:0]   ty,
    input  logic [COORD_W-1:0]   tz,
    input  logic [ANG_W-1:0]     angle_init,
    input  logic                 load_angle,
    input  logic [ANG_W-1:0]     angle_step,
    input  logic                 auto_rot,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [ANG_W-1:0]     angle,
    output logic                 vram_rd_en,
    output logic [ADDR_W-1:0]    vram_addr,
    input  logic [3*COORD_W-1:0] vram_rdata,
    output logic [COORD_W-1:0]   xf_a1,
    output logic [COORD_W-1:0]   xf_a2,
    output logic [COORD_W-1:0]   xf_a3,
    output logic [ANG_W-1:0]     xf_angle,
    output logic [COORD_W-1:0]   xf_tx,
    output logic [COORD_W-1:0]   xf_ty,
    output logic [COORD_W-1:0]   xf_tz,
    input  logic [COORD_W-1:0]   xf_o1,
    input  logic [COORD_W-1:0]   xf_o2,
    input  logic [COORD_W-1:0]   xf_o3,
    vertex_xform_seq_if.master   vout
);
    typedef enum logic [2:0] {IDLE, RD, XF, OUT, FIN} state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   base, cnt, idx;
    logic [COORD_W-1:0]  ltx, lty, ltz;
    logic                rot;
    logic [COORD_W-1:0]  ha1, ha2, ha3, htx, hty, htz;
    logic [ANG_W-1:0]    hang;
    logic                hs, last, kill;

    assign hs   = vout.out_valid && vout.out_ready;
    assign last = idx == cnt - 1'b1;
    assign kill = abort && state != IDLE;

    assign busy       = state == RD || state == XF || state == OUT;
    assign done       = state == FIN && !abort;
    assign vram_rd_en = state == RD;
    assign vram_addr  = base + idx;

    // the unit only looks at its operands in XF; elsewhere they replay the last XF values
    assign xf_a1    = state == XF ? vram_rdata[3*COORD_W-1:2*COORD_W] : ha1;
    assign xf_a2    = state == XF ? vram_rdata[2*COORD_W-1:COORD_W]   : ha2;
    assign xf_a3    = state == XF ? vram_rdata[COORD_W-1:0]           : ha3;
    assign xf_angle = state == XF ? angle : hang;
    assign xf_tx    = state == XF ? ltx : htx;
    assign xf_ty    = state == XF ? lty : hty;
    assign xf_tz    = state == XF ? ltz : htz;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? (vcount == '0 ? FIN : RD) : IDLE;
            RD:      state_nx = XF;
            XF:      state_nx = OUT;
            OUT:     state_nx = hs ? (vout.out_last ? FIN : RD) : OUT;
            default: state_nx = IDLE;
        endcase
        if (kill) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base           <= '0;
            cnt            <= '0;
            idx            <= '0;
            ltx            <= '0;
            lty            <= '0;
            ltz            <= '0;
            rot            <= 1'b0;
            angle          <= '0;
            ha1            <= '0;
            ha2            <= '0;
            ha3            <= '0;
            htx            <= '0;
            hty            <= '0;
            htz            <= '0;
            hang           <= '0;
            vout.out_valid <= 1'b0;
            vout.out_x     <= '0;
            vout.out_y     <= '0;
            vout.out_z     <= '0;
            vout.out_idx   <= '0;
            vout.out_last  <= 1'b0;
        end else begin
            if (state == IDLE && load_angle) angle <= angle_init;
            if (state == IDLE && start) begin
                base <= base_addr;
                cnt  <= vcount;
                idx  <= '0;
                ltx  <= tx;
                lty  <= ty;
                ltz  <= tz;
                rot  <= auto_rot;
            end
            if (state == XF) begin
                ha1           <= xf_a1;
                ha2           <= xf_a2;
                ha3           <= xf_a3;
                htx           <= xf_tx;
                hty           <= xf_ty;
                htz           <= xf_tz;
                hang          <= xf_angle;
                vout.out_x    <= xf_o1;
                vout.out_y    <= xf_o2;
                vout.out_z    <= xf_o3;
                vout.out_idx  <= idx;
                vout.out_last <= last;
            end
            if (state == OUT && hs && !vout.out_last) idx <= idx + 1'b1;
            if (state == FIN && rot && !abort) angle <= angle + angle_step;
            vout.out_valid <= kill ? 1'b0 : state == XF ? 1'b1 : hs ? 1'b0 : vout.out_valid;
        end
    end
endmodule

// File: tb/tb_vertex_xform_seq.sv
// tb_vertex_xform_seq: directed jobs against a RAM model and an identity-plus-translation unit model.
module tb_vertex_xform_seq;
    localparam int AW = 8;
    localparam int CW = 10;
    localparam int GW = 6;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [CW-1:0] z;
        logic [AW-1:0] idx;
        logic          last;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, load_angle = 1'b0, auto_rot = 1'b0, abort = 1'b0;
    logic [AW-1:0] base_addr = '0, vcount = '0;
    logic [CW-1:0] tx = '0, ty = '0, tz = '0;
    logic [GW-1:0] angle_init = '0, angle_step = '0;
    logic busy, done, vram_rd_en;
    logic [GW-1:0] angle, xf_angle;
    logic [AW-1:0] vram_addr;
    logic [3*CW-1:0] vram_rdata = '0;
    logic [CW-1:0] xf_a1, xf_a2, xf_a3, xf_tx, xf_ty, xf_tz, xf_o1, xf_o2, xf_o3;
    logic [3*CW-1:0] ram [256];

    exp_t sb[$];
    exp_t hold;
    int tests = 0, fails = 0;

    vertex_xform_seq_if #(.ADDR_W(AW), .COORD_W(CW)) vif ();

    vertex_xform_seq #(.ADDR_W(AW), .COORD_W(CW), .ANG_W(GW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .vcount(vcount),
        .tx(tx), .ty(ty), .tz(tz), .angle_init(angle_init), .load_angle(load_angle),
        .angle_step(angle_step), .auto_rot(auto_rot), .abort(abort), .busy(busy), .done(done),
        .angle(angle), .vram_rd_en(vram_rd_en), .vram_addr(vram_addr), .vram_rdata(vram_rdata),
        .xf_a1(xf_a1), .xf_a2(xf_a2), .xf_a3(xf_a3), .xf_angle(xf_angle),
        .xf_tx(xf_tx), .xf_ty(xf_ty), .xf_tz(xf_tz), .xf_o1(xf_o1), .xf_o2(xf_o2), .xf_o3(xf_o3),
        .vout(vif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (vram_rd_en) vram_rdata <= ram[vram_addr];
    assign xf_o1 = xf_a1 + xf_tx;
    assign xf_o2 = xf_a2 + xf_ty;
    assign xf_o3 = xf_a3 + xf_tz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic begin_job(input logic [AW-1:0] b, input logic [AW-1:0] n,
                             input logic [CW-1:0] x, input logic [CW-1:0] y,
                             input logic [CW-1:0] z, input logic rot);
        base_addr = b; vcount = n; tx = x; ty = y; tz = z; auto_rot = rot; start = 1'b1;
        for (int i = 0; i < int'(n); i++) begin
            logic [AW-1:0] a;
            exp_t e;
            a = b + AW'(i);
            e.x = ram[a][3*CW-1:2*CW] + x;
            e.y = ram[a][2*CW-1:CW] + y;
            e.z = ram[a][CW-1:0] + z;
            e.idx = AW'(i);
            e.last = i == int'(n) - 1;
            sb.push_back(e);
        end
        tick();
        start = 1'b0;
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        e = sb.size() > 0 ? sb.pop_front() : '0;
        chk({tag, "_x"}, 32'(vif.out_x), 32'(e.x));
        chk({tag, "_y"}, 32'(vif.out_y), 32'(e.y));
        chk({tag, "_z"}, 32'(vif.out_z), 32'(e.z));
        chk({tag, "_idx"}, 32'(vif.out_idx), 32'(e.idx));
        chk({tag, "_last"}, 32'(vif.out_last), 32'(e.last));
    endtask

    task automatic wait_out(input string tag);
        for (int k = 0; k < 20 && !vif.out_valid; k++) tick();
        chk({tag, "_valid"}, 32'(vif.out_valid), 1);
        check_out(tag);
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 20 && !done; k++) tick();
        chk({tag, "_done"}, 32'(done), 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = {CW'(i * 7), CW'(i * 3 + 1), CW'(1000 - i)};
        ram[4] = {10'd1, 10'd2, 10'd3};
        ram[5] = {10'd5, 10'd6, 10'd7};
        vif.out_ready = 1'b0;
        tick(3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_angle", 32'(angle), 0);
        chk("rst_valid", 32'(vif.out_valid), 0);
        chk("rst_rd", 32'(vram_rd_en), 0);
        rst_n = 1'b1;
        tick();

        // basic two-vertex job, cycle-exact
        angle_init = '0; load_angle = 1'b1; tick(); load_angle = 1'b0;
        vif.out_ready = 1'b1;
        begin_job(8'd4, 8'd2, '0, '0, '0, 1'b0);
        chk("b_rd0", 32'(vram_rd_en), 1);
        chk("b_addr0", 32'(vram_addr), 4);
        chk("b_busy", 32'(busy), 1);
        tick();
        chk("b_xf_a1", 32'(xf_a1), 1);
        chk("b_novalid", 32'(vif.out_valid), 0);
        tick();
        chk("b_valid0", 32'(vif.out_valid), 1);
        check_out("b_v0");
        tick();
        chk("b_drop", 32'(vif.out_valid), 0);
        chk("b_rd1", 32'(vram_rd_en), 1);
        chk("b_addr1", 32'(vram_addr), 5);
        tick(2);
        chk("b_valid1", 32'(vif.out_valid), 1);
        check_out("b_v1");
        tick();
        chk("b_done", 32'(done), 1);
        chk("b_busy_fin", 32'(busy), 0);
        tick();
        chk("b_done_pulse", 32'(done), 0);

        // backpressure
        vif.out_ready = 1'b0;
        begin_job(8'd10, 8'd2, 10'd100, 10'h3CE, 10'd3, 1'b0);
        tick(2);
        hold = sb[0];
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(vif.out_valid), 1);
            chk("bp_x", 32'(vif.out_x), 32'(hold.x));
            chk("bp_z", 32'(vif.out_z), 32'(hold.z));
            chk("bp_idx", 32'(vif.out_idx), 32'(hold.idx));
            chk("bp_last", 32'(vif.out_last), 32'(hold.last));
            chk("bp_nord", 32'(vram_rd_en), 0);
            tick();
        end
        vif.out_ready = 1'b1;
        check_out("bp_v0");
        tick();
        chk("bp_drop", 32'(vif.out_valid), 0);
        chk("bp_addr1", 32'(vram_addr), 11);
        wait_out("bp_v1");
        wait_done("bp");
        tick();

        // empty job
        begin_job(8'd7, 8'd0, '0, '0, '0, 1'b0);
        chk("e_done", 32'(done), 1);
        chk("e_rd", 32'(vram_rd_en), 0);
        tick();
        chk("e_done_pulse", 32'(done), 0);
        chk("e_rd2", 32'(vram_rd_en), 0);

        // address wrap
        begin_job(8'd255, 8'd2, 10'd1, 10'd2, 10'd3, 1'b0);
        chk("w_addr0", 32'(vram_addr), 255);
        tick(2);
        chk("w_valid0", 32'(vif.out_valid), 1);
        check_out("w_v0");
        tick();
        chk("w_rd1", 32'(vram_rd_en), 1);
        chk("w_addr1", 32'(vram_addr), 0);
        tick(2);
        chk("w_valid1", 32'(vif.out_valid), 1);
        check_out("w_v1");
        wait_done("w");
        tick();

        // angle advance; a start while busy is ignored
        angle_init = 6'd60; load_angle = 1'b1; tick(); load_angle = 1'b0;
        chk("a_load", 32'(angle), 60);
        angle_step = 6'd8;
        begin_job(8'd20, 8'd1, '0, '0, '0, 1'b1);
        start = 1'b1; vcount = 8'd5;
        tick();
        start = 1'b0;
        chk("a_xf_angle", 32'(xf_angle), 60);
        tick();
        chk("a_valid", 32'(vif.out_valid), 1);
        check_out("a_v0");
        tick();
        chk("a_done", 32'(done), 1);
        tick();
        chk("a_angle", 32'(angle), 4);
        tick(4);
        chk("a_no_extra", 32'(vif.out_valid), 0);
        chk("a_idle", 32'(busy), 0);

        // abort in XF
        begin_job(8'd4, 8'd2, '0, '0, '0, 1'b1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        sb.delete();
        chk("ab_busy", 32'(busy), 0);
        chk("ab_angle", 32'(angle), 4);
        for (int k = 0; k < 3; k++) begin
            chk("ab_valid", 32'(vif.out_valid), 0);
            chk("ab_done", 32'(done), 0);
            tick();
        end
        begin_job(8'd5, 8'd1, 10'd1, 10'd1, 10'd1, 1'b1);
        wait_out("ab_new");
        wait_done("ab_new");
        tick();
        chk("ab_new_angle", 32'(angle), 12);

        // asynchronous reset while a vertex is held
        vif.out_ready = 1'b0;
        begin_job(8'd4, 8'd1, '0, '0, '0, 1'b0);
        tick(2);
        chk("r_valid_pre", 32'(vif.out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("r_valid", 32'(vif.out_valid), 0);
        chk("r_busy", 32'(busy), 0);
        chk("r_angle", 32'(angle), 0);
        sb.delete();
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("r_no_done", 32'(done), 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
